// File: rtl/feature_extractor.sv
// Streaming Sobel-X 3x3 convolution, ReLU and 2x2/stride-2 max pooling over one raster frame.
// Emits the pooled features in raster order, then a single-cycle done pulse.
module feature_extractor #(
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_signal,
  input  logic               pixel_valid_in,
  input  logic [7:0]         pixel_in,
  output logic signed [21:0] final_result_out,
  output logic               final_result_valid,
  output logic               final_done_signal
);
  localparam int unsigned PoolW  = (IMG_WIDTH - 2) / 2;
  localparam int unsigned PoolH  = (IMG_HEIGHT - 2) / 2;
  localparam int unsigned NumOut = PoolW * PoolH;
  localparam int unsigned CW     = $clog2(IMG_WIDTH);
  localparam int unsigned RW     = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned PW     = $clog2(PoolW);
  localparam int unsigned OW     = $clog2(NumOut + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic          accept, emit;

  logic [7:0] lb0_q [IMG_WIDTH];
  logic [7:0] lb1_q [IMG_WIDTH];
  logic [7:0] win_q [3][3];

  logic          w_valid_q, w_odd_col_q, w_odd_row_q;
  logic [PW-1:0] w_px_q;
  logic [CW-1:0] conv_col;

  logic               s1_valid_q, s1_odd_col_q, s1_odd_row_q;
  logic [PW-1:0]      s1_px_q;
  logic signed [21:0] s1_conv_q;

  logic               s2_valid_q, s2_odd_row_q;
  logic [PW-1:0]      s2_px_q;
  logic signed [21:0] s2_hmax_q, prev_q;

  logic signed [21:0] hbuf_q [PoolW];
  logic signed [21:0] conv_d, relu, hmax_d, vmax_d;

  // Row counter reaching IMG_HEIGHT marks a complete frame; later pixels are dropped.
  assign accept   = (state_q == StRun) && pixel_valid_in && (row_q != RW'(IMG_HEIGHT));
  assign emit     = s2_valid_q && s2_odd_row_q;
  assign conv_col = col_q - CW'(2);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      StIdle: begin
        if (start_signal) begin
          state_d   = StRun;
          col_d     = '0;
          row_d     = '0;
          out_cnt_d = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (col_q == CW'(IMG_WIDTH - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        if (emit) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == OW'(NumOut - 1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= StIdle;
      col_q             <= '0;
      row_q             <= '0;
      out_cnt_q         <= '0;
      final_done_signal <= 1'b0;
    end else begin
      state_q           <= state_d;
      col_q             <= col_d;
      row_q             <= row_d;
      out_cnt_q         <= out_cnt_d;
      final_done_signal <= (state_q == StDone);
    end
  end

  // Column c of the window is {row r-2, row r-1, row r}; stale rows are never used before rewrite.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= pixel_in;
      lb1_q[col_q] <= lb0_q[col_q];
      for (int ky = 0; ky < 3; ky++) begin
        win_q[ky][0] <= win_q[ky][1];
        win_q[ky][1] <= win_q[ky][2];
      end
      win_q[0][2] <= lb1_q[col_q];
      win_q[1][2] <= lb0_q[col_q];
      win_q[2][2] <= pixel_in;
    end
  end

  function automatic logic signed [21:0] zext(input logic [7:0] p);
    return $signed({14'd0, p});
  endfunction

  always_comb begin
    conv_d = (zext(win_q[0][0]) - zext(win_q[0][2]))
           + ((zext(win_q[1][0]) - zext(win_q[1][2])) <<< 1)
           + (zext(win_q[2][0]) - zext(win_q[2][2]));
    relu   = s1_conv_q[21] ? '0 : s1_conv_q;
    hmax_d = (relu > prev_q) ? relu : prev_q;
    vmax_d = (s2_hmax_q > hbuf_q[s2_px_q]) ? s2_hmax_q : hbuf_q[s2_px_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_valid_q          <= 1'b0;
      w_odd_col_q        <= 1'b0;
      w_odd_row_q        <= 1'b0;
      w_px_q             <= '0;
      s1_valid_q         <= 1'b0;
      s1_odd_col_q       <= 1'b0;
      s1_odd_row_q       <= 1'b0;
      s1_px_q            <= '0;
      s1_conv_q          <= '0;
      prev_q             <= '0;
      s2_valid_q         <= 1'b0;
      s2_odd_row_q       <= 1'b0;
      s2_px_q            <= '0;
      s2_hmax_q          <= '0;
      final_result_valid <= 1'b0;
      final_result_out   <= '0;
    end else begin
      w_valid_q <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
      if (accept) begin
        w_odd_col_q <= col_q[0];
        w_odd_row_q <= row_q[0];
        w_px_q      <= PW'(conv_col >> 1);
      end
      s1_valid_q <= w_valid_q;
      if (w_valid_q) begin
        s1_conv_q    <= conv_d;
        s1_odd_col_q <= w_odd_col_q;
        s1_odd_row_q <= w_odd_row_q;
        s1_px_q      <= w_px_q;
      end
      if (s1_valid_q && !s1_odd_col_q) prev_q <= relu;
      s2_valid_q <= s1_valid_q && s1_odd_col_q;
      if (s1_valid_q && s1_odd_col_q) begin
        s2_hmax_q    <= hmax_d;
        s2_odd_row_q <= s1_odd_row_q;
        s2_px_q      <= s1_px_q;
      end
      final_result_valid <= emit;
      if (emit) final_result_out <= vmax_d;
    end
  end

  // Even conv rows park their horizontal pair-max here until the odd row arrives.
  always_ff @(posedge clk) begin
    if (s2_valid_q && !s2_odd_row_q) hbuf_q[s2_px_q] <= s2_hmax_q;
  end

endmodule

// File: tb/tb_feature_extractor.sv
// Scoreboard bench for feature_extractor: software conv/ReLU/pool model feeds an expected queue,
// a negedge monitor collects DUT results, and each scenario task compares them inline.
module tb_feature_extractor;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_signal = 1'b0;
  logic               pixel_valid_in = 1'b0;
  logic [7:0]         pixel_in = 8'd0;
  logic signed [21:0] final_result_out;
  logic               final_result_valid;
  logic               final_done_signal;

  feature_extractor #(.IMG_WIDTH(32), .IMG_HEIGHT(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_signal      (start_signal),
    .pixel_valid_in    (pixel_valid_in),
    .pixel_in          (pixel_in),
    .final_result_out  (final_result_out),
    .final_result_valid(final_result_valid),
    .final_done_signal (final_done_signal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int img[32][32];
  int exp_q[$];
  int obs_q[$];
  int done_cnt = 0, done_cyc = 0, first_cyc = -1, last_cyc = 0, acc33 = 0, acc_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (final_result_valid) begin
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      obs_q.push_back(int'(final_result_out));
    end
    if (final_done_signal) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int kval(input int ky, input int kx);
    int w;
    w = (ky == 1) ? 2 : 1;
    if (kx == 1) return 0;
    return (kx == 0) ? w : -w;
  endfunction

  function automatic int conv_at(input int y, input int x);
    int s;
    s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        s += img[y + ky][x + kx] * kval(ky, kx);
    return s;
  endfunction

  function automatic void push_expected();
    int m, c;
    for (int py = 0; py < 15; py++)
      for (int px = 0; px < 15; px++) begin
        m = 0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            c = conv_at(2 * py + dy, 2 * px + dx);
            if (c > m) m = c;
          end
        exp_q.push_back(m);
      end
  endfunction

  // mode: 0 xor, 1 constant, 2 decreasing ramp, 3 increasing ramp, 4 vertical edge
  function automatic void fill_frame(input int mode);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        case (mode)
          0:       img[y][x] = 100 + (x ^ y);
          1:       img[y][x] = 128;
          2:       img[y][x] = 200 - 4 * x;
          3:       img[y][x] = 4 * x;
          default: img[y][x] = (x < 16) ? 200 : 50;
        endcase
  endfunction

  task automatic clear_obs();
    exp_q.delete();
    obs_q.delete();
    done_cnt  = 0;
    first_cyc = -1;
  endtask

  task automatic send_frame(input bit with_start, input bit gaps, input int npix);
    @(negedge clk);
    start_signal   = with_start;
    pixel_valid_in = 1'b0;
    if (npix == 1024) push_expected();
    for (int i = 0; i < npix; i++) begin
      @(negedge clk);
      start_signal   = 1'b0;
      pixel_valid_in = 1'b1;
      pixel_in       = 8'(img[i / 32][i % 32]);
      if (i == 3 * 32 + 3) acc33 = cyc + 1;
      if (i == npix - 1) acc_last = cyc + 1;
      if (gaps && (i % 7 == 6)) begin
        @(negedge clk);
        pixel_valid_in = 1'b0;
        pixel_in       = 8'hff;
      end
    end
    @(negedge clk);
    pixel_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (final_result_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: got %b expected 0", final_result_valid);
    end
    n_cmp++;
    if (final_done_signal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done: got %b expected 0", final_done_signal);
    end
    n_cmp++;
    if (final_result_out !== 22'sd0) begin
      n_bad++;
      $display("FAIL reset_out: got %0d expected 0", final_result_out);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame(input string name, input int mode, input bit gaps);
    int e, o;
    fill_frame(mode);
    clear_obs();
    send_frame(1'b1, gaps, 1024);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 225) begin
      n_bad++;
      $display("FAIL %s count: got %0d expected 225", name, obs_q.size());
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
    end
    n_cmp++;
    if (done_cyc != last_cyc + 1) begin
      n_bad++;
      $display("FAIL %s done_timing: got cycle %0d expected %0d", name, done_cyc, last_cyc + 1);
    end
    n_cmp++;
    if (first_cyc != acc33 + 3) begin
      n_bad++;
      $display("FAIL %s first_latency: got cycle %0d expected %0d", name, first_cyc, acc33 + 3);
    end
    n_cmp++;
    if (last_cyc != acc_last + 3) begin
      n_bad++;
      $display("FAIL %s last_latency: got cycle %0d expected %0d", name, last_cyc, acc_last + 3);
    end
    for (int i = 0; i < 225; i++) begin
      if (exp_q.size() == 0 || obs_q.size() == 0) break;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s value[%0d]: got %0d expected %0d", name, i, o, e);
      end
    end
  endtask

  task automatic test_abort();
    fill_frame(0);
    clear_obs();
    send_frame(1'b1, 1'b0, 500);
    #2 rst = 1'b0;
    obs_q.delete();
    done_cnt = 0;
    #1;
    n_cmp++;
    if (final_result_valid !== 1'b0 || final_result_out !== 22'sd0) begin
      n_bad++;
      $display("FAIL abort_async: got valid %b out %0d expected 0/0",
               final_result_valid, final_result_out);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0 || done_cnt != 0) begin
      n_bad++;
      $display("FAIL abort_quiet: got %0d valids %0d dones expected 0/0", obs_q.size(), done_cnt);
    end
  endtask

  task automatic test_no_start();
    fill_frame(0);
    clear_obs();
    send_frame(1'b0, 1'b0, 1024);
    repeat (15) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0 || done_cnt != 0) begin
      n_bad++;
      $display("FAIL no_start: got %0d valids %0d dones expected 0/0", obs_q.size(), done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_frame("xor", 0, 1'b0);
    test_frame("constant", 1, 1'b0);
    test_frame("ramp_down", 2, 1'b0);
    test_frame("ramp_up", 3, 1'b0);
    test_frame("vertical_edge", 4, 1'b0);
    test_frame("xor_gaps", 0, 1'b1);
    test_abort();
    test_no_start();
    test_frame("xor_after_abort", 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
